clock_freeze_ctrl: RTL and testbench
====================================

# clock_freeze_ctrl

Run/freeze/single-step controller for the processor clock, in the clock subsystem next to the 10 s monostable. It divides `clock50` into a one-cycle core clock-enable pulse and stops that pulse on a freeze request or a breakpoint. While frozen it issues one enable per debounced step-button press and can resume automatically after a timeout. The core and the clock-gating logic consume `core_tick`. `frozen` drives the board status LED.

## Interface
- `DIV`, default 50: clock50 cycles per core tick; must be at least 2 (50 gives 1 MHz).
- `TIMEOUT`, default 500000000: frozen cycles before auto-resume (10 s at 50 MHz).
- `DEBOUNCE`, default 1000000: cycles `step_btn` must be stable before it is accepted (20 ms).
- `clock50  in  1`  system clock, 50 MHz.
- `rst  in  1`  reset; asynchronous, active-high.
- `freeze_req  in  1`  level input; while high, the core is held frozen.
- `break_hit  in  1`  one-cycle pulse from the core at a breakpoint; requests a freeze.
- `resume  in  1`  one-cycle pulse; leaves FROZEN when `freeze_req` is low.
- `step_btn  in  1`  raw pushbutton, active-high, asynchronous to the clock.
- `auto_resume_en  in  1`  enables the timeout resume.
- `core_tick  out  1`  registered one-cycle core clock enable.
- `frozen  out  1`  high in FROZEN and STEP.
- `state  out  2`  current state code.
- `timeout_pulse  out  1`  one-cycle pulse when an auto-resume fires.

## Operation
- The divider `div_cnt` counts 0..DIV-1 in every state and wraps. `tick_raw` = (`div_cnt` == DIV-1).
- Reset values: state RUN, `div_cnt` 0, timer 0, all outputs 0, debouncer level 0.
- States: RUN=2'b00, FROZEN=2'b01, STEP=2'b10. Code 2'b11 is illegal and returns to RUN.
- **RUN**
  - `core_tick` = `tick_raw`, registered.
  - `freeze_req` or `break_hit` → FROZEN.
- **FROZEN**
  - `core_tick` = 0.
  - The timer counts up only while `auto_resume_en` is high and `freeze_req` is low. Otherwise it is held at 0.
  - Priority, highest first:
    1. Accepted step press → STEP, timer cleared.
    2. `resume` with `freeze_req` low → RUN.
    3. Timer == TIMEOUT-1 → RUN, with `timeout_pulse` high for 1 cycle.
- **STEP**
  - Waits for the next `tick_raw`, emits exactly one `core_tick`, then returns to FROZEN with the timer at 0.
  - `break_hit`, `resume` and further step presses are ignored here.
- **Step press**
  - `step_btn` passes through a 2-FF synchronizer and a stability counter.
  - The debounced level changes only after DEBOUNCE consecutive cycles of an unchanged synchronized value.
  - Its rising edge gives a 1-cycle `step_pulse`. Presses are accepted only in FROZEN; in RUN or STEP the pulse is discarded and not queued.
- **Simultaneous events**
  - In RUN, freeze beats tick: a `tick_raw` in the same cycle as `freeze_req`/`break_hit` is suppressed.
  - In FROZEN, step wins over resume and timeout.
- **Reset mid-operation**: outputs clear immediately, asynchronously, from any state, including STEP with its tick pending.
- **Widths**
  - `div_cnt` is $clog2(DIV) bits.
  - The timer is $clog2(TIMEOUT) bits and never wraps, since it exits at TIMEOUT-1.
  - The debounce counter is $clog2(DEBOUNCE+1) bits.

## Timing
- The state register and all outputs update on posedge `clock50`. `rst` acts asynchronously.
- **Freeze latency**: with `freeze_req` or `break_hit` sampled high at edge k, `core_tick` is 0 from edge k onward and `frozen` is 1 after edge k.
- **Tick period in RUN**: exactly DIV cycles; `core_tick` is high for one cycle.
- **Step latency**: 1 to DIV cycles from STEP entry to `core_tick`. FROZEN is re-entered on the edge after the tick.
- **Button latency**: 2 synchronizer cycles + DEBOUNCE cycles + 1 cycle from a clean press to `step_pulse`.
- **Auto-resume**: TIMEOUT counted cycles in FROZEN, then RUN. The first `core_tick` follows at the next divider wrap.

## Structure
- Shared constants go in `config.v` as defines: the state codes and the default DIV/TIMEOUT/DEBOUNCE values.
- Sub-module `step_debouncer`: clock, reset, raw input → debounced level and rise pulse.
- The divider, timer and FSM stay in `clock_freeze_ctrl`.

## Test plan
Benches use DIV=4, TIMEOUT=20, DEBOUNCE=3.
1. **Reset then free run**: `rst` pulse, all inputs low → `core_tick` every 4 cycles, `frozen`=0, `state`=00.
2. **Breakpoint freeze**: `break_hit` pulse in the same cycle as `tick_raw` → that tick is suppressed, `frozen`=1, no `core_tick` for 100 cycles; then `resume` → RUN and ticks restart at the next divider wrap.
3. **Single step**:
   - Frozen with `freeze_req`=1; `step_btn` held for 10 cycles → exactly one `core_tick`, within 4 cycles of STEP entry, then `state`=01.
   - A 2-cycle glitch on `step_btn` → no step.
4. **Auto-resume**: `break_hit`, `auto_resume_en`=1, `freeze_req`=0 → `timeout_pulse` after 20 frozen cycles, `state`=00. With `freeze_req`=1 the timer holds at 0 and there is no timeout.
5. **Collisions**: step press and `resume` accepted in the same cycle → STEP wins, one tick, back to FROZEN.
6. **Asynchronous reset in STEP** before its tick → `core_tick` never fires, `state`=00 immediately.

Source files
------------

// File: rtl/clock_freeze_ctrl_pkg.sv
// Shared state codes, default timing constants and width helper for the
// processor clock run/freeze/step controller.
package clock_freeze_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FROZEN = 2'b01,
    ST_STEP   = 2'b10
  } state_t;

  // 50 MHz clock50: 1 MHz core tick, 10 s auto-resume, 20 ms button debounce
  localparam int unsigned DEF_DIV      = 50;
  localparam int unsigned DEF_TIMEOUT  = 500000000;
  localparam int unsigned DEF_DEBOUNCE = 1000000;

  // Counter width for a modulus n, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_freeze_ctrl_step_debouncer.sv
// Step pushbutton conditioning: 2-FF synchronizer, stability counter,
// debounced level and a one-cycle pulse on its rising edge.
module clock_freeze_ctrl_step_debouncer
  import clock_freeze_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clock50,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE + 1);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Level flips only after DEBOUNCE consecutive synchronized samples that differ from it
  always_ff @(posedge clock50 or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_freeze_ctrl.sv
// Run/freeze/single-step controller: divides clock50 into a one-cycle core
// enable and gates it on freeze requests, breakpoints and step presses.
module clock_freeze_ctrl
  import clock_freeze_ctrl_pkg::*;
#(
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic       clock50,
  input  logic       rst,
  input  logic       freeze_req,
  input  logic       break_hit,
  input  logic       resume,
  input  logic       step_btn,
  input  logic       auto_resume_en,
  output logic       core_tick,
  output logic       frozen,
  output logic [1:0] state,
  output logic       timeout_pulse
);

  localparam int unsigned DIV_W = cnt_width(DIV);
  localparam int unsigned TMR_W = cnt_width(TIMEOUT);

  state_t           cur_state;
  logic [DIV_W-1:0] div_cnt;
  logic [TMR_W-1:0] timer;
  logic             tick_raw;
  logic             timer_en;
  logic             timer_done;
  logic             step_pulse;
  logic             step_level_unused;

  assign state      = cur_state;
  assign tick_raw   = (div_cnt == DIV_W'(DIV - 1));
  assign timer_en   = auto_resume_en & ~freeze_req;
  assign timer_done = timer_en & (timer == TMR_W'(TIMEOUT - 1));

  clock_freeze_ctrl_step_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) u_step_debouncer (
    .clock50 (clock50),
    .rst     (rst),
    .raw     (step_btn),
    .level   (step_level_unused),
    .rise    (step_pulse)
  );

  // Free-running divider, independent of the run/freeze state
  always_ff @(posedge clock50 or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick_raw) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Control FSM; a freeze in the same cycle as tick_raw suppresses that tick
  always_ff @(posedge clock50 or posedge rst) begin
    if (rst) begin
      cur_state     <= ST_RUN;
      timer         <= '0;
      core_tick     <= 1'b0;
      frozen        <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (cur_state)
        ST_RUN: begin
          timer <= '0;
          if (freeze_req || break_hit) begin
            cur_state <= ST_FROZEN;
            core_tick <= 1'b0;
            frozen    <= 1'b1;
          end else begin
            core_tick <= tick_raw;
            frozen    <= 1'b0;
          end
        end

        ST_FROZEN: begin
          core_tick <= 1'b0;
          frozen    <= 1'b1;
          if (step_pulse) begin
            cur_state <= ST_STEP;
            timer     <= '0;
          end else if (resume && !freeze_req) begin
            cur_state <= ST_RUN;
            frozen    <= 1'b0;
            timer     <= '0;
          end else if (timer_done) begin
            cur_state     <= ST_RUN;
            frozen        <= 1'b0;
            timer         <= '0;
            timeout_pulse <= 1'b1;
          end else if (timer_en) begin
            timer <= timer + TMR_W'(1);
          end else begin
            timer <= '0;
          end
        end

        // One tick at the next divider wrap, then back to FROZEN on the following edge
        ST_STEP: begin
          frozen <= 1'b1;
          timer  <= '0;
          if (core_tick) begin
            cur_state <= ST_FROZEN;
            core_tick <= 1'b0;
          end else begin
            core_tick <= tick_raw;
          end
        end

        default: begin
          cur_state <= ST_RUN;
          core_tick <= 1'b0;
          frozen    <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_freeze_ctrl.sv
// Bench for clock_freeze_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_clock_freeze_ctrl;

  localparam int DIV      = 4;
  localparam int TIMEOUT  = 20;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       freeze_req = 1'b0;
  logic       break_hit = 1'b0;
  logic       resume = 1'b0;
  logic       step_btn = 1'b0;
  logic       auto_resume_en = 1'b0;
  logic       core_tick;
  logic       frozen;
  logic [1:0] state;
  logic       timeout_pulse;

  int n_checks = 0;
  int n_errors = 0;

  clock_freeze_ctrl #(
    .DIV      (DIV),
    .TIMEOUT  (TIMEOUT),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clock50        (clk),
    .rst            (rst),
    .freeze_req     (freeze_req),
    .break_hit      (break_hit),
    .resume         (resume),
    .step_btn       (step_btn),
    .auto_resume_en (auto_resume_en),
    .core_tick      (core_tick),
    .frozen         (frozen),
    .state          (state),
    .timeout_pulse  (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges since reset, mode 0=run 1=frozen 2=step
  int m_cyc, m_mode, m_timer;
  bit m_tick, m_tp;
  bit m_lvl, m_lvl_prev, m_pulse;
  bit raw_hist[$];
  bit syn_hist[$];

  task automatic model_reset();
    m_cyc = 0; m_mode = 0; m_timer = 0;
    m_tick = 0; m_tp = 0;
    m_lvl = 0; m_lvl_prev = 0; m_pulse = 0;
    raw_hist.delete();
    syn_hist.delete();
  endtask

  task automatic model_step();
    bit t, p, s2, flip, nt;
    t = ((m_cyc % DIV) == DIV - 1);
    p = m_pulse;
    // synchronized value is the raw button as sampled two edges ago
    s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 1'b0;
    raw_hist.push_back(step_btn);
    if (raw_hist.size() > 4) raw_hist.delete(0);
    syn_hist.push_back(s2);
    if (syn_hist.size() > DEBOUNCE) syn_hist.delete(0);
    flip = (syn_hist.size() == DEBOUNCE);
    foreach (syn_hist[i]) if (syn_hist[i] == m_lvl) flip = 0;
    m_pulse = m_lvl && !m_lvl_prev;
    m_lvl_prev = m_lvl;
    if (flip) begin
      m_lvl = !m_lvl;
      syn_hist.delete();
    end
    nt = m_tick;
    m_tp = 0;
    case (m_mode)
      0: begin
        if (freeze_req || break_hit) begin m_mode = 1; nt = 0; m_timer = 0; end
        else nt = t;
      end
      1: begin
        nt = 0;
        if (p) begin m_mode = 2; m_timer = 0; end
        else if (resume && !freeze_req) m_mode = 0;
        else if (auto_resume_en && !freeze_req && m_timer == TIMEOUT - 1) begin
          m_mode = 0; m_tp = 1; m_timer = 0;
        end
        else m_timer = (auto_resume_en && !freeze_req) ? m_timer + 1 : 0;
      end
      default: begin
        if (m_tick) begin m_mode = 1; nt = 0; m_timer = 0; end
        else nt = t;
      end
    endcase
    m_tick = nt;
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_eq("core_tick", 32'(core_tick), 32'(m_tick));
    check_eq("frozen", 32'(frozen), 32'(m_mode != 0));
    check_eq("state", 32'(state), 32'(m_mode));
    check_eq("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
  endtask

  task automatic apply_reset();
    freeze_req = 0; break_hit = 0; resume = 0; step_btn = 0; auto_resume_en = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_core_tick", 32'(core_tick), 0);
    check_eq("rst_frozen", 32'(frozen), 0);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_timeout", 32'(timeout_pulse), 0);
    rst = 0;
  endtask

  initial begin
    int n, ticks, lat, exp_lat, hold;
    bit seen, found;

    // 1: reset then free run
    apply_reset();
    ticks = 0;
    repeat (12) begin cycle(); ticks += int'(core_tick); end
    check_eq("free_run_ticks", 32'(ticks), 3);

    // 2: breakpoint in the same cycle as tick_raw
    while ((m_cyc % DIV) != DIV - 1) cycle();
    break_hit = 1; cycle(); break_hit = 0;
    check_eq("brk_suppress", 32'(core_tick), 0);
    check_eq("brk_state", 32'(state), 1);
    ticks = 0;
    repeat (100) begin cycle(); ticks += int'(core_tick); end
    check_eq("frozen_ticks", 32'(ticks), 0);
    resume = 1; cycle(); resume = 0;
    check_eq("resume_state", 32'(state), 0);
    exp_lat = ((DIV - 1) - (m_cyc % DIV) + DIV) % DIV + 1;
    lat = 0; found = 0;
    for (int i = 0; i < 2 * DIV && !found; i++) begin
      cycle(); lat++;
      if (core_tick) found = 1;
    end
    check_eq("restart_lat", 32'(lat), 32'(exp_lat));

    // 3: single step while freeze_req is held, then a glitch
    freeze_req = 1; cycle();
    step_btn = 1;
    ticks = 0; lat = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) step_btn = 0;
      cycle();
      if (seen && ticks == 0) lat++;
      if (state == 2'b10) seen = 1;
      ticks += int'(core_tick);
    end
    check_eq("step_ticks", 32'(ticks), 1);
    check_eq("step_lat_ok", 32'(lat >= 1 && lat <= DIV), 1);
    check_eq("step_back_state", 32'(state), 1);
    step_btn = 1; cycle(); cycle(); step_btn = 0;
    seen = 0;
    repeat (15) begin cycle(); if (state == 2'b10) seen = 1; end
    check_eq("glitch_no_step", 32'(seen), 0);
    freeze_req = 0; resume = 1; cycle(); resume = 0;

    // 4: auto-resume, then timer held by freeze_req
    auto_resume_en = 1;
    break_hit = 1; cycle(); break_hit = 0;
    n = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(); n++;
      if (timeout_pulse) found = 1;
    end
    check_eq("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check_eq("timeout_state", 32'(state), 0);
    freeze_req = 1;
    n = 0;
    repeat (40) begin cycle(); n += int'(timeout_pulse); end
    check_eq("held_no_timeout", 32'(n), 0);
    check_eq("held_state", 32'(state), 1);
    freeze_req = 0; auto_resume_en = 0;
    resume = 1; cycle(); resume = 0;

    // 5: step press and resume accepted in the same cycle
    break_hit = 1; cycle(); break_hit = 0;
    step_btn = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (m_pulse) begin
        resume = 1; cycle(); resume = 0;
        found = 1;
      end
    end
    check_eq("collide_found", 32'(found), 1);
    check_eq("collide_state", 32'(state), 2);
    ticks = 0;
    repeat (10) begin cycle(); ticks += int'(core_tick); end
    check_eq("collide_ticks", 32'(ticks), 1);
    check_eq("collide_back", 32'(state), 1);
    step_btn = 0;
    repeat (10) cycle();

    // 6: asynchronous reset while STEP waits for its tick
    resume = 1; cycle(); resume = 0;
    freeze_req = 1; cycle();
    step_btn = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (state == 2'b10 && !core_tick) found = 1;
    end
    check_eq("step6_reached", 32'(found), 1);
    #2 rst = 1;
    #1;
    check_eq("async_state", 32'(state), 0);
    check_eq("async_core_tick", 32'(core_tick), 0);
    check_eq("async_frozen", 32'(frozen), 0);
    ticks = 0;
    repeat (6) begin @(posedge clk); #1 ticks += int'(core_tick); end
    check_eq("async_no_tick", 32'(ticks), 0);
    apply_reset();

    // Random stimulus against the model
    hold = 0;
    for (int i = 0; i < 1000; i++) begin
      if (hold == 0) begin
        step_btn = !step_btn;
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      break_hit = ($urandom_range(0, 19) == 0);
      resume = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) freeze_req = !freeze_req;
      if ($urandom_range(0, 49) == 0) auto_resume_en = !auto_resume_en;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
